// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source IDLE/PENDING/CLAIMED gating, fixed-priority arbitration, claim/complete over the data bus.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on ext_irq.
module irq_ctrl #(
    parameter int unsigned NSRC = 4
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            CS,
    input  logic            dbus_we,
    input  logic            dbus_re,
    input  logic [4:0]      dbus_addr5,
    input  logic [31:0]     dbus_in,
    output logic [31:0]     dbus_out,
    input  logic            timer_irq,
    input  logic [NSRC-1:0] ext_irq,
    output logic            irq_req,
    output logic [4:0]      irq_id
);

    localparam int unsigned NMAX = NSRC + 1;
    localparam int unsigned IDW  = 5;
    localparam int unsigned DW   = 32;

    localparam logic [4:0] A_PENDING = 5'h00;
    localparam logic [4:0] A_ENABLE  = 5'h04;
    localparam logic [4:0] A_CLAIM   = 5'h08;
    localparam logic [4:0] A_EDGE    = 5'h0C;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_CLAIMED = 2'd2
    } state_t;

    logic [NSRC-1:0] ext_smp;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NSRC-1:0] ext_meta;
    logic [NSRC-1:0] ext_sync;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            ext_meta <= '0;
            ext_sync <= '0;
        end else begin
            ext_meta <= ext_irq;
            ext_sync <= ext_meta;
        end
    end

    assign ext_smp = ext_sync;
`else
    assign ext_smp = ext_irq;
`endif

    // Source vectors are indexed by interrupt ID.
    logic [NMAX:1] smp;
    logic [NMAX:1] prev_q;
    logic [NMAX:1] edge_mode;
    logic [NMAX:1] rise;
    logic [NMAX:1] edge_evt;
    logic [NMAX:1] trig;
    logic [NMAX:1] pend_vec;
    logic [NMAX:1] enable_q;
    logic [NMAX:2] edge_q;
    logic [NMAX:1] missed_q;
    logic [NMAX:1] missed_d;
    state_t        state_q [NMAX:1];
    state_t        state_d [NMAX:1];

    logic [IDW-1:0] best;
    logic [IDW-1:0] cmp_id;
    logic           wr_en;
    logic           rd_en;
    logic           claim_fire;
    logic           complete_fire;
    logic           unused_din;

    assign smp       = {ext_smp, timer_irq};
    assign edge_mode = {edge_q, 1'b0};
    assign rise      = smp & ~prev_q;
    assign edge_evt  = edge_mode & rise;
    assign trig      = edge_evt | (~edge_mode & smp);

    assign wr_en         = CS && dbus_we;
    assign rd_en         = CS && dbus_re;
    assign claim_fire    = rd_en && !dbus_we && (dbus_addr5 == A_CLAIM) && (best != '0);
    assign complete_fire = wr_en && (dbus_addr5 == A_CLAIM);
    assign cmp_id        = dbus_in[IDW-1:0];
    assign unused_din    = ^dbus_in;

    always_comb begin
        pend_vec = '0;
        for (int i = 1; i <= int'(NMAX); i++) begin
            pend_vec[i] = (state_q[i] == S_PENDING);
        end
    end

    // Lowest pending-and-enabled ID wins.
    always_comb begin
        best = '0;
        for (int i = int'(NMAX); i >= 1; i--) begin
            if (pend_vec[i] && enable_q[i]) begin
                best = IDW'(i);
            end
        end
    end

    // Per-source next state; a claim or complete colliding with a new edge keeps that edge.
    always_comb begin
        missed_d = missed_q;
        for (int i = 1; i <= int'(NMAX); i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (trig[i]) begin
                        state_d[i] = S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (claim_fire && (best == IDW'(i))) begin
                        state_d[i]  = S_CLAIMED;
                        missed_d[i] = edge_evt[i];
                    end
                end
                S_CLAIMED: begin
                    if (complete_fire && (cmp_id == IDW'(i))) begin
                        state_d[i]  = (missed_q[i] || edge_evt[i]) ? S_PENDING : S_IDLE;
                        missed_d[i] = 1'b0;
                    end else if (edge_evt[i]) begin
                        missed_d[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i]  = S_IDLE;
                    missed_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 1; i <= int'(NMAX); i++) begin
                state_q[i] <= S_IDLE;
            end
            missed_q <= '0;
        end else begin
            for (int i = 1; i <= int'(NMAX); i++) begin
                state_q[i] <= state_d[i];
            end
            missed_q <= missed_d;
        end
    end

    // Config registers, edge history and the registered core request.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            enable_q <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            irq_req  <= 1'b0;
            irq_id   <= '0;
        end else begin
            if (wr_en && (dbus_addr5 == A_ENABLE)) begin
                enable_q <= dbus_in[NMAX:1];
            end
            if (wr_en && (dbus_addr5 == A_EDGE)) begin
                edge_q <= dbus_in[NMAX:2];
            end
            prev_q  <= smp;
            irq_req <= (best != '0);
            irq_id  <= best;
        end
    end

    always_comb begin
        dbus_out = '0;
        if (rd_en) begin
            case (dbus_addr5)
                A_PENDING: dbus_out = DW'({pend_vec, 1'b0});
                A_ENABLE:  dbus_out = DW'({enable_q, 1'b0});
                A_CLAIM:   dbus_out = dbus_we ? '0 : DW'(best);
                A_EDGE:    dbus_out = DW'({edge_q, 2'b00});
                default:   dbus_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand sequences for claim/complete collisions, and random traffic vs a reference model.
module tb_irq_ctrl;

    localparam int unsigned NSRC = 4;
    localparam int NMAX = 5;
    localparam int OP_IDLE = 0;
    localparam int OP_RD = 1;
    localparam int OP_WR = 2;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] din = '0;
    logic        tmr = 1'b0;
    logic [3:0]  ext = '0;
    logic [31:0] dout;
    logic        req;
    logic [4:0]  id;

    always #5 clk_in = ~clk_in;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .CS(cs), .dbus_we(we), .dbus_re(re),
        .dbus_addr5(addr), .dbus_in(din), .dbus_out(dout),
        .timer_irq(tmr), .ext_irq(ext), .irq_req(req), .irq_id(id)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: state codes 0 idle, 1 pending, 2 claimed, indexed by ID.
    int  ms [NMAX+1];
    bit  mm [NMAX+1];
    bit  men [NMAX+1];
    bit  medg [NMAX+1];
    bit  mprev [NMAX+1];
    bit  mreq = 1'b0;
    logic [4:0] mid = '0;

    function automatic int m_best();
        for (int i = 1; i <= NMAX; i++) begin
            if (ms[i] == 1 && men[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_read();
        logic [31:0] r;
        r = '0;
        if (!(cs && re)) return r;
        case (addr)
            5'h00: for (int i = 1; i <= NMAX; i++) r[i] = (ms[i] == 1);
            5'h04: for (int i = 1; i <= NMAX; i++) r[i] = men[i];
            5'h08: r = we ? 32'h0 : 32'(m_best());
            5'h0C: for (int i = 1; i <= NMAX; i++) r[i] = medg[i];
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic m_clock();
        int b;
        int cid;
        bit claim;
        bit cmp;
        bit s;
        bit r;
        bit ev;
        if (!rst_n) begin
            for (int i = 0; i <= NMAX; i++) begin
                ms[i] = 0; mm[i] = 0; men[i] = 0; medg[i] = 0; mprev[i] = 0;
            end
            mreq = 1'b0;
            mid = '0;
            return;
        end
        b = m_best();
        claim = cs && re && !we && addr == 5'h08;
        cmp = cs && we && addr == 5'h08;
        cid = int'(din[4:0]);
        for (int i = 1; i <= NMAX; i++) begin
            s = (i == 1) ? tmr : ext[i-2];
            r = s && !mprev[i];
            ev = medg[i] && r;
            case (ms[i])
                0: if (medg[i] ? r : s) ms[i] = 1;
                1: if (claim && b == i) begin ms[i] = 2; mm[i] = ev; end
                default: begin
                    if (cmp && cid == i) begin
                        ms[i] = (mm[i] || ev) ? 1 : 0;
                        mm[i] = 0;
                    end else if (ev) begin
                        mm[i] = 1;
                    end
                end
            endcase
            mprev[i] = s;
        end
        if (cs && we && addr == 5'h04) for (int i = 1; i <= NMAX; i++) men[i] = din[i];
        if (cs && we && addr == 5'h0C) for (int i = 2; i <= NMAX; i++) medg[i] = din[i];
        mreq = (b != 0);
        mid = 5'(b);
    endtask

    task automatic bus(input int op, input logic [4:0] a, input logic [31:0] d);
        cs = (op != OP_IDLE);
        we = (op == OP_WR);
        re = (op == OP_RD);
        addr = a;
        din = d;
    endtask

    // Called with inputs set just after a falling edge; returns just after the next falling edge.
    task automatic step(output logic [31:0] out_dut, output logic [31:0] out_mod);
        #1;
        out_dut = dout;
        out_mod = m_read();
        @(posedge clk_in);
        m_clock();
        @(negedge clk_in);
    endtask

    typedef struct {
        int          op;
        logic [4:0]  a;
        logic [31:0] d;
        bit          t;
        logic [3:0]  e;
        logic [31:0] xo;
        bit          xreq;
        logic [4:0]  xid;
    } vec_t;

    function automatic vec_t mk(int op, logic [4:0] a, logic [31:0] d, bit t, logic [3:0] e,
                                logic [31:0] xo, bit xreq, logic [4:0] xid);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.t = t; v.e = e; v.xo = xo; v.xreq = xreq; v.xid = xid;
        return v;
    endfunction

    vec_t tbl[$];

    task automatic hand(input string name, input int op, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] e, input bit do_chk, input logic [31:0] xo);
        logic [31:0] od;
        logic [31:0] om;
        bus(op, a, d);
        ext = e;
        step(od, om);
        if (do_chk) chk(name, od, xo);
    endtask

    task automatic do_reset();
        logic [31:0] od;
        logic [31:0] om;
        bus(OP_IDLE, 5'h00, 32'h0);
        tmr = 1'b0;
        ext = '0;
        rst_n = 1'b0;
        step(od, om);
        step(od, om);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] od;
        logic [31:0] om;
        int sel;

        // op, addr, data, timer, ext, exp dbus_out, exp irq_req, exp irq_id (after the clock)
        tbl.push_back(mk(OP_RD,   5'h00, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h04, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h0C, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h04, 32'h6, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     1, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     1, 4'h0, 32'h0,  1, 5'd1));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     1, 4'h0, 32'h1,  1, 5'd1));
        tbl.push_back(mk(OP_RD,   5'h00, 0,     1, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h1, 1, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     1, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     1, 4'h0, 32'h0,  1, 5'd1));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h1,  1, 5'd1));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h1, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h04, 32'h3C,0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h0C, 32'h3C,0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h0C, 0,     0, 4'h0, 32'h3C, 0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h5, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h0, 32'h0,  1, 5'd2));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h2,  1, 5'd2));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h4,  1, 5'd4));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h2, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h4, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h00, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h2, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h0, 32'h0,  1, 5'd3));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h3,  1, 5'd3));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h2, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h00, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h3, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h0, 32'h0,  1, 5'd3));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h3,  1, 5'd3));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h3, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h04, 32'h0, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h1, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h00, 0,     0, 4'h0, 32'h4,  0, 5'd0));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_WR,   5'h04, 32'h4, 0, 4'h0, 32'h0,  0, 5'd0));
        tbl.push_back(mk(OP_IDLE, 5'h00, 0,     0, 4'h0, 32'h0,  1, 5'd2));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h7, 0, 4'h0, 32'h0,  1, 5'd2));
        tbl.push_back(mk(OP_WR,   5'h08, 32'h1F,0, 4'h0, 32'h0,  1, 5'd2));
        tbl.push_back(mk(OP_RD,   5'h00, 0,     0, 4'h0, 32'h4,  1, 5'd2));
        tbl.push_back(mk(OP_RD,   5'h08, 0,     0, 4'h0, 32'h2,  1, 5'd2));

        @(negedge clk_in);
        do_reset();
        chk("reset irq_req", 32'(req), 32'h0);
        chk("reset irq_id", 32'(id), 32'h0);

        foreach (tbl[k]) begin
            bus(tbl[k].op, tbl[k].a, tbl[k].d);
            tmr = tbl[k].t;
            ext = tbl[k].e;
            step(od, om);
            chk($sformatf("vec%0d dbus_out", k), od, tbl[k].xo);
            chk($sformatf("vec%0d irq_req", k), 32'(req), 32'(tbl[k].xreq));
            chk($sformatf("vec%0d irq_id", k), 32'(id), 32'(tbl[k].xid));
        end

        // Reset while source 2 is claimed discards everything.
        do_reset();
        chk("rst mid-claim irq_req", 32'(req), 32'h0);
        chk("rst mid-claim irq_id", 32'(id), 32'h0);
        hand("rst PENDING", OP_RD, 5'h00, 0, 4'h0, 1, 32'h0);
        hand("rst ENABLE", OP_RD, 5'h04, 0, 4'h0, 1, 32'h0);
        hand("rst EDGE", OP_RD, 5'h0C, 0, 4'h0, 1, 32'h0);
        hand("rst CLAIM", OP_RD, 5'h08, 0, 4'h0, 1, 32'h0);

        // Reserved and out-of-range register bits.
        hand("", OP_WR, 5'h04, 32'hFFFF_FFFF, 4'h0, 0, 0);
        hand("", OP_WR, 5'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0);
        hand("ENABLE mask", OP_RD, 5'h04, 0, 4'h0, 1, 32'h3E);
        hand("EDGE mask", OP_RD, 5'h0C, 0, 4'h0, 1, 32'h3C);
        hand("unmapped read", OP_RD, 5'h10, 0, 4'h0, 1, 32'h0);

        // Claim and complete colliding with a new edge on source 2.
        do_reset();
        hand("", OP_WR, 5'h04, 32'h4, 4'h0, 0, 0);
        hand("", OP_WR, 5'h0C, 32'h4, 4'h0, 0, 0);
        hand("", OP_IDLE, 5'h00, 0, 4'h1, 0, 0);
        hand("", OP_IDLE, 5'h00, 0, 4'h0, 0, 0);
        hand("claim+edge id", OP_RD, 5'h08, 0, 4'h1, 1, 32'h2);
        hand("claim+edge held", OP_RD, 5'h00, 0, 4'h0, 1, 32'h0);
        hand("", OP_WR, 5'h08, 32'h2, 4'h0, 0, 0);
        hand("missed re-pend", OP_RD, 5'h00, 0, 4'h0, 1, 32'h4);
        hand("second claim", OP_RD, 5'h08, 0, 4'h0, 1, 32'h2);
        hand("", OP_WR, 5'h08, 32'h2, 4'h1, 0, 0);
        hand("complete+edge", OP_RD, 5'h00, 0, 4'h0, 1, 32'h4);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) tmr = ~tmr;
            for (int b = 0; b < int'(NSRC); b++) begin
                if ($urandom_range(0, 5) == 0) ext[b] = ~ext[b];
            end
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: bus(OP_IDLE, 5'h00, 0);
                3, 4:    bus(OP_RD, 5'h08, 0);
                5:       bus(OP_RD, 5'($urandom_range(0, 7) * 4), 0);
                6:       bus(OP_WR, 5'h08, ($urandom_range(0, 9) == 0) ? 32'h1F : 32'($urandom_range(0, 7)));
                7:       bus(OP_WR, 5'h04, $urandom);
                8:       bus(OP_WR, 5'h0C, $urandom);
                default: bus(OP_WR, 5'($urandom_range(0, 7) * 4), $urandom);
            endcase
            rst_n = ($urandom_range(0, 599) != 0);
            step(od, om);
            if (re) chk($sformatf("rand%0d dbus_out", n), od, om);
            chk($sformatf("rand%0d irq_req", n), 32'(req), 32'(mreq));
            chk($sformatf("rand%0d irq_id", n), 32'(id), 32'(mid));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
